// File: rtl/bit_serial_alu_ctrl.sv
// Sequencer driving one external 1-bit ALU slice for WIDTH cycles, LSB first, to build a WIDTH-bit result.
// Latency: WIDTH cycles from accept edge to done pulse; one operation per WIDTH+2 cycles.
// Backpressure: ready is high only in IDLE; start outside IDLE is ignored, nothing is queued.
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [2:0]       slice_c,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  input  logic             slice_f,
  input  logic             slice_cout,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             carry_q;

  // Only add (000) and sub (001) propagate carry between bit cycles.
  logic             arith;
  logic [WIDTH-1:0] res_next;

  assign arith    = (op_q[2:1] == 2'b00);
  assign res_next = {slice_f, res_sr};

  // The operand shift registers fill with zeros and op/carry are cleared at the
  // final edge, so these read as 0 in IDLE and DONE without extra gating.
  assign slice_c   = op_q;
  assign slice_a   = a_sr[0];
  assign slice_b   = b_sr[0];
  assign slice_cin = carry_q;

  // Sequencer FSM with all datapath registers and registered handshake/flag outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      op_q      <= 3'b000;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      cnt       <= '0;
      carry_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && ready) begin
            op_q    <= op;
            a_sr    <= opa;
            b_sr    <= opb;
            cnt     <= '0;
            // Subtract is a + ~b + 1, so the first bit starts with carry in set.
            carry_q <= (op == 3'b001);
            ready   <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          res_sr  <= res_next[WIDTH-1:1];
          cnt     <= cnt + 1'b1;
          carry_q <= arith ? slice_cout : 1'b0;
          if (cnt == LAST_BIT) begin
            // Publish the whole result and flags at once; nothing external moves mid-run.
            result    <= res_next;
            carry_out <= arith & slice_cout;
            overflow  <= arith & (carry_q ^ slice_cout);
            zero      <= ~|res_next;
            done      <= 1'b1;
            carry_q   <= 1'b0;
            op_q      <= 3'b000;
            cnt       <= '0;
            state     <= DONE;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
